// File: rtl/freq_worker_sync.sv
// Synchronisation agent for one hash-building worker: steps the per-element phase chain,
// parks on crossbar interrupt at element boundaries and resumes or retires on cont.
module freq_worker_sync #(
    parameter int unsigned LENGTH_ARRAY = 100,
    parameter int unsigned NUM_STATE    = 7,
    parameter int unsigned STALL_WIDTH  = 16,
    localparam int unsigned IW = (LENGTH_ARRAY > 1) ? $clog2(LENGTH_ARRAY) : 1,
    localparam int unsigned SW = (NUM_STATE > 1) ? $clog2(NUM_STATE) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   step_done_i,
    input  logic                   interrupt_i,
    input  logic                   cont_i,
    input  logic                   transfered_i,
    output logic [SW-1:0]          state_o,
    output logic [IW-1:0]          index_o,
    output logic                   waiting_o,
    output logic                   phase_start_o,
    output logic                   done_o,
    output logic [STALL_WIDTH-1:0] stall_cycles_o
);

    typedef enum logic [SW-1:0] {
        StWait,
        StWaitForInterrupt,
        StFetch,
        StFirstTempIndex,
        StRdHashOccurr,
        StCollisionCal,
        StHashBuild
    } state_e;

    localparam logic [IW-1:0] LastIndex = IW'(LENGTH_ARRAY - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          index_q, index_d;
    logic                   waiting_q, waiting_d;
    logic                   phase_start_q, phase_start_d;
    logic                   done_q, done_d;
    logic [STALL_WIDTH-1:0] stall_q, stall_d;
    logic                   irq_pending_q, irq_pending_d;
    logic                   finished_q, finished_d;
    logic                   processing;

    assign processing = (state_q != StWait) && (state_q != StWaitForInterrupt);

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        phase_start_d = 1'b0;
        done_d        = 1'b0;
        finished_d    = finished_q;
        irq_pending_d = irq_pending_q | (interrupt_i & processing);
        stall_d       = stall_q;
        if (waiting_q && (stall_q != '1)) begin
            stall_d = stall_q + STALL_WIDTH'(1);
        end

        unique case (state_q)
            StWait: begin
                if (start_i) begin
                    state_d       = StFetch;
                    index_d       = '0;
                    stall_d       = '0;
                    finished_d    = 1'b0;
                    irq_pending_d = 1'b0;
                    phase_start_d = 1'b1;
                end
            end
            StWaitForInterrupt: begin
                if (cont_i) begin
                    if (finished_q || transfered_i) begin
                        state_d    = StWait;
                        finished_d = 1'b0;
                    end else begin
                        state_d       = StFetch;
                        phase_start_d = 1'b1;
                    end
                end
            end
            StFetch, StFirstTempIndex, StRdHashOccurr, StCollisionCal: begin
                if (step_done_i) begin
                    state_d       = state_e'(state_q + SW'(1));
                    phase_start_d = 1'b1;
                end
            end
            StHashBuild: begin
                if (step_done_i) begin
                    if (index_q == LastIndex) begin
                        // Completion outranks a coincident park request.
                        state_d       = StWaitForInterrupt;
                        finished_d    = 1'b1;
                        done_d        = 1'b1;
                        irq_pending_d = 1'b0;
                    end else if (irq_pending_q || interrupt_i) begin
                        state_d       = StWaitForInterrupt;
                        index_d       = index_q + IW'(1);
                        irq_pending_d = 1'b0;
                    end else begin
                        state_d       = StFetch;
                        index_d       = index_q + IW'(1);
                        phase_start_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StWait;
            end
        endcase

        waiting_d = (state_d == StWaitForInterrupt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StWait;
            index_q       <= '0;
            waiting_q     <= 1'b0;
            phase_start_q <= 1'b0;
            done_q        <= 1'b0;
            stall_q       <= '0;
            irq_pending_q <= 1'b0;
            finished_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            waiting_q     <= waiting_d;
            phase_start_q <= phase_start_d;
            done_q        <= done_d;
            stall_q       <= stall_d;
            irq_pending_q <= irq_pending_d;
            finished_q    <= finished_d;
        end
    end

    assign state_o        = state_q;
    assign index_o        = index_q;
    assign waiting_o      = waiting_q;
    assign phase_start_o  = phase_start_q;
    assign done_o         = done_q;
    assign stall_cycles_o = stall_q;

endmodule
